pixel_stream_source: RTL and testbench
======================================

Name: pixel_stream_source

Overview:
Frame-buffered raster pixel source that feeds the Sobel edge-detector input stream (valid/pixel, no ready). A host or testbench loads one WIDTH x HEIGHT 8-bit frame through a write port. On start, the block replays the frame in raster order as a valid-qualified stream, with sof/eol markers and a stall input for pacing.

Parameters:
WIDTH, 128, pixels per row; must match the downstream filter's WIDTH.
HEIGHT, 128, rows per frame.
H_BLANK, 4, idle cycles inserted after each row; used only when BLANK_EN is defined, and must be >= 1.
AW, 14, write address width; must satisfy 2^AW >= WIDTH*HEIGHT.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
wr_en  in  1  frame memory write strobe
wr_addr  in  AW  linear address, row*WIDTH+col
wr_data  in  8  pixel to store
start  in  1  begin streaming one frame (level sampled)
stall  in  1  pause stream; no read issued this cycle
valid_out  out  1  pixel_out valid this cycle
pixel_out  out  8  streamed pixel
sof  out  1  high with the first pixel of the frame (row 0, col 0)
eol  out  1  high with the last pixel of each row (col WIDTH-1)
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse, cycle after the last pixel's valid_out

Behaviour:
- Reset: valid_out=0, pixel_out=0, sof=0, eol=0, busy=0, done=0; FSM enters IDLE; col and row counters cleared.
  - Memory contents are not cleared.
  - A reset mid-frame aborts the frame immediately, with no done pulse.
- Memory: WIDTH*HEIGHT x 8, synchronous write, synchronous read with 1-cycle latency.
  - A write with wr_addr >= WIDTH*HEIGHT is ignored.
  - A write while busy=1 is ignored (frame is frozen during streaming).
- FSM states: IDLE, STREAM, BLANK (BLANK_EN only), FLUSH.
  - IDLE: start=1 -> STREAM; busy goes high next cycle; col=0, row=0.
  - STREAM: each cycle with stall=0, issue read at row*WIDTH+col, then advance col; on col wrap, advance row.
    - Stall=1: no read, counters hold.
    - Issuing the read of col=WIDTH-1 on the last row -> FLUSH.
    - Otherwise, issuing col=WIDTH-1 -> BLANK if BLANK_EN, else remain in STREAM.
  - BLANK: count H_BLANK cycles with no reads issued, then -> STREAM. Stall is ignored in BLANK.
  - FLUSH: the final read data emerges; -> IDLE next cycle; done=1 in that cycle; busy=0 from then.
- Output pipeline: a read issued in cycle t produces valid_out=1 and pixel_out=mem data in cycle t+1.
  - sof and eol are pipelined identically with the read.
  - In every cycle with no read issued in the previous cycle: valid_out=0, sof=0, eol=0, and pixel_out holds its last value.
- Latency: start high in cycle T with stall=0 -> first valid_out (with sof) in cycle T+2.
  - Without BLANK_EN and with no stalls, the frame is WIDTH*HEIGHT consecutive valid cycles.
  - done is pulsed in cycle T+2+WIDTH*HEIGHT.
- Simultaneous events:
  - start while busy is ignored.
  - start and wr_en in the same IDLE cycle: the write completes and streaming begins. The read of that address reflects the write only if it issues later, which is guaranteed because the first read issues at T+1.
  - stall=1 in the same cycle as start does not block acceptance; it only delays the first read.
- Counters: col wraps at WIDTH-1 to 0, and row increments on that wrap. There is no overflow beyond HEIGHT-1 because the FSM leaves STREAM first.

Optional Feature:
Macro BLANK_EN.
- Defined: H_BLANK idle cycles (valid_out=0) after every row's last read, including between rows only; no blank after the final row. This emulates horizontal blanking so the downstream line-buffer pipeline sees gaps.
- Undefined: the BLANK state and its counter are not built; rows are issued back-to-back, and H_BLANK is unused.

Test Plan:
- Load mem[i] = i[7:0] for all 16384 addresses, pulse start at cycle T, no stall, BLANK_EN off.
  - Expect valid_out high T+2..T+16385, pixel_out 0,1,..255,0,.. in order.
  - Expect sof only at T+2, eol every 128th valid, done at T+16386.
- Same frame with stall high for 3 cycles mid-row 5 -> exactly 3 valid_out gaps; pixel sequence unbroken; done delayed by 3 cycles.
- BLANK_EN on, H_BLANK=4 -> exactly 4 idle cycles after each eol except the last; total frame time 16384+127*4 cycles; sof/eol positions unchanged.
- Write wr_addr=0, data 0xAA while busy, and a write to wr_addr=16384 in IDLE -> neither affects memory; the next frame streams the original mem[0].
- Assert rst during row 10 -> next cycle valid_out=0, busy=0, no done; a subsequent start streams from pixel 0 with sof.
- start pulsed again while busy at row 50 -> ignored; a single done pulse only.

Source files
------------

// File: rtl/pixel_stream_source.sv
// Frame-buffered raster pixel source: a host loads one WIDTH x HEIGHT frame, then start replays it as a valid/sof/eol stream.
// Optional horizontal blanking between rows is built only when the BLANK_EN macro is defined.
module pixel_stream_source #(
    parameter int WIDTH   = 128,
    parameter int HEIGHT  = 128,
    parameter int H_BLANK = 4,
    parameter int AW      = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          start,
    input  logic          stall,
    output logic          valid_out,
    output logic [7:0]    pixel_out,
    output logic          sof,
    output logic          eol,
    output logic          busy,
    output logic          done
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int MAW  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [AW:0]   NPIX_EXT = (AW + 1)'(NPIX);

    generate
        if (H_BLANK < 1 || (2 ** AW) < NPIX) begin : g_param_check
            $error("pixel_stream_source: H_BLANK must be >= 1 and 2**AW >= WIDTH*HEIGHT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
`ifdef BLANK_EN
        ,
        S_BLANK  = 2'd3
`endif
    } state_t;

    state_t          r_state;
    logic [7:0]      r_mem [NPIX];
    logic [7:0]      r_pixel;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [MAW-1:0]  r_addr;
    logic            r_valid;
    logic            r_sof;
    logic            r_eol;
    logic            r_busy;
    logic            r_done;

    logic            w_rd_issue;
    logic            w_wr_ok;
    logic            w_col_last;
    logic            w_row_last;

`ifdef BLANK_EN
    localparam int BW = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
    logic [BW-1:0]   r_blank_cnt;
`endif

    assign w_rd_issue = (r_state == S_STREAM) && !stall;
    // Frame is frozen while streaming; out-of-range addresses are dropped.
    assign w_wr_ok    = wr_en && !r_busy && ({1'b0, wr_addr} < NPIX_EXT);
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr[MAW-1:0]] <= wr_data;
        end
    end

    // Read register holds its value when no read issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixel <= 8'h00;
        end else if (w_rd_issue) begin
            r_pixel <= r_mem[r_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef BLANK_EN
            r_blank_cnt <= '0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_valid <= w_rd_issue;
            r_sof   <= w_rd_issue && (r_col == '0) && (r_row == '0);
            r_eol   <= w_rd_issue && w_col_last;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_STREAM;
                        r_busy  <= 1'b1;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_addr  <= '0;
                    end
                end
                S_STREAM: begin
                    if (!stall) begin
                        r_addr <= r_addr + 1'b1;
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_state <= S_FLUSH;
                            end else begin
                                r_row <= r_row + 1'b1;
`ifdef BLANK_EN
                                r_state     <= S_BLANK;
                                r_blank_cnt <= BW'(H_BLANK - 1);
`endif
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
`ifdef BLANK_EN
                S_BLANK: begin
                    if (r_blank_cnt == '0) begin
                        r_state <= S_STREAM;
                    end else begin
                        r_blank_cnt <= r_blank_cnt - 1'b1;
                    end
                end
`endif
                S_FLUSH: begin
                    // Last pixel is on the output now; done lands the cycle after.
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign valid_out = r_valid;
    assign pixel_out = r_pixel;
    assign sof       = r_sof;
    assign eol       = r_eol;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Scoreboard bench for pixel_stream_source on a small 16x8 frame: expected pixels are queued at start and popped on valid_out.
module tb_pixel_stream_source;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int AW = 8;
    localparam int HB = 2;
    localparam int N  = W * H;
`ifdef BLANK_EN
    localparam int HB_T = HB;
`else
    localparam int HB_T = 0;
`endif

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          start;
    logic          stall;
    logic          valid_out;
    logic [7:0]    pixel_out;
    logic          sof;
    logic          eol;
    logic          busy;
    logic          done;

    pixel_stream_source #(
        .WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stall(stall), .valid_out(valid_out), .pixel_out(pixel_out),
        .sof(sof), .eol(eol), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
    } exp_t;

    exp_t       q[$];
    logic [7:0] model [N];
    int         checks = 0;
    int         errors = 0;

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({valid_out, sof, eol, busy, done} !== 5'b0 || pixel_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b sof=%b eol=%b busy=%b done=%b pix=%h, want all 0",
                     valid_out, sof, eol, busy, done, pixel_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_frame();
        for (int i = 0; i < N; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = 8'((i * 7 + 3) & 255);
            model[i] = 8'((i * 7 + 3) & 255);
            @(negedge clk);
        end
        wr_en = 1'b0;
        $display("load: %0d pixels written", N);
    endtask

    task automatic push_frame();
        exp_t e;
        q.delete();
        for (int i = 0; i < N; i++) begin
            e.pix = model[i]; e.sof = (i == 0); e.eol = ((i % W) == W - 1);
            q.push_back(e);
        end
    endtask

    // Entered and left at a negedge. pre: stalled cycles right after start; mid: stall length inside row 5.
    task automatic run_frame(input string name, input int pre, input int mid,
                             input bit wr_busy, input bit restart, input bit same_wr);
        int t0, c, first_v, last_v, done_cyc, ndone, nvalid, gaps, exp_first, exp_done, mid_start, limit;
        bit exp_busy;
        exp_t e;
        t0 = cyc;
        start = 1'b1;
        stall = (pre > 0);
        if (same_wr) begin
            wr_en = 1'b1; wr_addr = AW'(5); wr_data = 8'hC3; model[5] = 8'hC3;
        end
        push_frame();
        mid_start = t0 + 1 + pre + 5 * (W + HB_T) + 7;
        exp_first = t0 + 2 + pre;
        exp_done  = t0 + 2 + N + (H - 1) * HB_T + pre + mid;
        limit     = N + (H - 1) * HB_T + pre + mid + 12;
        first_v = -1; last_v = -1; done_cyc = -1; ndone = 0; nvalid = 0; gaps = 0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            c = cyc;
            start = restart && (c == t0 + 1 + 3 * (W + HB_T));
            wr_en = wr_busy && (c == t0 + 6);
            wr_addr = '0; wr_data = 8'hAA;
            stall = (c <= t0 + pre) || (mid > 0 && c >= mid_start && c < mid_start + mid);
            if (valid_out) begin
                if (first_v < 0) first_v = c;
                if (last_v >= 0) gaps += c - last_v - 1;
                last_v = c;
                nvalid++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_valid: got pixel %h at cycle %0d, want no valid", name, pixel_out, c - t0);
                end else begin
                    e = q.pop_front();
                    if (pixel_out !== e.pix || sof !== e.sof || eol !== e.eol) begin
                        errors++;
                        $display("FAIL %s pixel#%0d: got pix=%h sof=%b eol=%b, want pix=%h sof=%b eol=%b",
                                 name, nvalid - 1, pixel_out, sof, eol, e.pix, e.sof, e.eol);
                    end
                end
            end else begin
                checks++;
                if (sof !== 1'b0 || eol !== 1'b0) begin
                    errors++;
                    $display("FAIL %s idle_markers: got sof=%b eol=%b at cycle %0d, want 0 0", name, sof, eol, c - t0);
                end
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            exp_busy = (c > t0) && (c < exp_done);
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL %s busy: got %b at cycle %0d, want %b", name, busy, c - t0, exp_busy);
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        start = 1'b0; stall = 1'b0; wr_en = 1'b0;
        checks++;
        if (first_v != exp_first) begin
            errors++;
            $display("FAIL %s first_valid: got T+%0d, want T+%0d", name, first_v - t0, exp_first - t0);
        end
        checks++;
        if (done_cyc != exp_done || ndone != 1) begin
            errors++;
            $display("FAIL %s done: got T+%0d (%0d pulses), want T+%0d (1 pulse)", name, done_cyc - t0, ndone, exp_done - t0);
        end
        checks++;
        if (nvalid != N || q.size() != 0) begin
            errors++;
            $display("FAIL %s count: got %0d valids (%0d unmatched), want %0d", name, nvalid, q.size(), N);
        end
        checks++;
        if (gaps != (H - 1) * HB_T + mid) begin
            errors++;
            $display("FAIL %s gaps: got %0d idle cycles inside frame, want %0d", name, gaps, (H - 1) * HB_T + mid);
        end
        $display("frame %s: first T+%0d done T+%0d valids %0d gaps %0d", name, first_v - t0, done_cyc - t0, nvalid, gaps);
    endtask

    task automatic test_frame_basic();
        run_frame("basic", 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        run_frame("mid_stall", 0, 3, 1'b0, 1'b0, 1'b0);
        run_frame("start_stall", 2, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_write_guard();
        wr_en = 1'b1; wr_addr = AW'(N); wr_data = 8'h55;
        @(negedge clk);
        wr_addr = 8'hFF;
        @(negedge clk);
        wr_en = 1'b0;
        $display("write_guard: out-of-range writes to %0d and 255 issued", N);
        run_frame("busy_write", 0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame("start_with_write", 0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_restart();
        run_frame("restart_ignored", 0, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int t0;
        int bad;
        t0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 1 + 5 * (W + HB_T) + 3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_running: got busy=%b valid=%b before reset, want 1 1", busy, valid_out);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (valid_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sof !== 1'b0 || eol !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got valid=%b busy=%b done=%b sof=%b eol=%b, want all 0",
                     valid_out, busy, done, sof, eol);
        end
        bad = 0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            if (valid_out !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %0d cycles with activity after abort, want 0", bad);
        end
        $display("reset_mid: frame aborted in row 5");
        run_frame("after_reset", 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        load_frame();
        test_frame_basic();
        test_stall();
        test_write_guard();
        test_back_to_back();
        test_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
